// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_pkg
// Purpose : Shared types and helpers for the shift-add multiplier.
// Rev     : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Controller states of the sequential multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Bits needed to count 0 .. w-1 (at least one bit)
  function automatic int CNT_W(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_abs_val.sv
`default_nettype none
// ============================================================================
// Module  : abs_val
// Purpose : Combinational magnitude helper. When enabled, a negative
//           two's-complement input is negated; the WIDTH-bit unsigned result
//           covers the most negative value (2^(WIDTH-1)) without an extra bit.
// Rev     : 1.0  initial release
// ============================================================================
module abs_val #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] mag_o
);

  logic w_negate;

  assign w_negate = en_i & value_i[WIDTH-1];
  assign mag_o    = w_negate ? (~value_i + 1'b1) : value_i;

endmodule : abs_val
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_mult
// Purpose : Parametrised sequential shift-add multiplier, signed or unsigned
//           per operation, one multiplier bit retired per clock, with a
//           busy/done handshake. Signed products are formed from operand
//           magnitudes and negated once at the end.
// Rev     : 1.0  initial release
// ============================================================================
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] ab,
  output logic               busy,
  output logic               done
);

  localparam int              CW       = CNT_W(WIDTH);
  localparam int              PW       = 2 * WIDTH;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  // Operand magnitudes, only meaningful at the accept edge
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  abs_val #(.WIDTH(WIDTH)) u_abs_a (
    .value_i (a),
    .en_i    (signed_mode),
    .mag_o   (a_mag)
  );

  abs_val #(.WIDTH(WIDTH)) u_abs_b (
    .value_i (b),
    .en_i    (signed_mode),
    .mag_o   (b_mag)
  );

  mult_state_t      state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q,    neg_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [PW-1:0]    ab_q,     ab_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Partial-product datapath for the current RUN iteration
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // State and datapath registers; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ab_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath: accept in IDLE, one add/shift per RUN edge,
  // final sign correction written to the product register on the last bit
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ab_d     = ab_q;
    done_d   = 1'b0;

    addend   = mplier_q[0] ? (PW'(mcand_q) << cnt_q) : '0;
    acc_sum  = acc_q + addend;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          ab_d    = neg_q ? (~acc_sum + 1'b1) : acc_sum;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign ab   = ab_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : shift_add_mult
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_add_mult
// Purpose : Directed and randomised self-checking bench for shift_add_mult
//           at WIDTH = 8 and WIDTH = 16.
// Rev     : 1.0  initial release
// ============================================================================
module tb_shift_add_mult;

  logic        clk;
  logic        rst;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] ab8;
  logic        busy8, done8;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic [31:0] ab16;
  logic        busy16, done16;

  int checks;
  int errors;

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .signed_mode (sm8),
    .a           (a8),
    .b           (b8),
    .ab          (ab8),
    .busy        (busy8),
    .done        (done8)
  );

  shift_add_mult #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (start16),
    .signed_mode (sm16),
    .a           (a16),
    .b           (b16),
    .ab          (ab16),
    .busy        (busy16),
    .done        (done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product, independent of the shift-add algorithm
  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint lx, ly, p;
    lx = s ? longint'($signed(x)) : longint'(x);
    ly = s ? longint'($signed(y)) : longint'(y);
    p  = lx * ly;
    return p[31:0];
  endfunction

  // One complete 8-bit operation: accept, latency, result, return to IDLE
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                     input logic [15:0] exp, input string tag);
    int n;
    @(negedge clk); a8 = ta; b8 = tb; sm8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    chk(32'(busy8), 32'd1, {tag, "_busy"});
    @(negedge clk); start8 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done8 && n < 40);
    chk(32'(n), 32'd8, {tag, "_latency"});
    chk(32'(ab8), 32'(exp), {tag, "_ab"});
    @(posedge clk); #1;
    chk(32'({busy8, done8}), 32'd0, {tag, "_idle"});
  endtask

  // One complete 16-bit operation
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                      input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk); a16 = ta; b16 = tb; sm16 = ts; start16 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start16 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done16 && n < 60);
    chk(32'(n), 32'd16, {tag, "_latency"});
    chk(ab16, exp, {tag, "_ab"});
    @(posedge clk); #1;
    chk(32'({busy16, done16}), 32'd0, {tag, "_idle"});
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(32'(ab8), 32'd0, "rst_ab8");
    chk(32'({busy8, done8}), 32'd0, "rst_bd8");
    chk(ab16, 32'd0, "rst_ab16");
    @(negedge clk); rst = 1'b0;

    // Unsigned 26 x 80 with start held for 5 edges: only one operation
    @(negedge clk); a8 = 8'd26; b8 = 8'd80; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    chk(32'(busy8), 32'd1, "hold_busy");
    repeat (4) @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    n = 4;
    do begin
      @(posedge clk); #1; n++;
    end while (!done8 && n < 40);
    chk(32'(n), 32'd8, "hold_latency");
    chk(32'(ab8), 32'd2080, "hold_ab");
    repeat (4) begin
      @(posedge clk); #1;
      chk(32'({busy8, done8}), 32'd0, "hold_single_op");
    end

    // Signed corner cases and unsigned maximum
    op8(8'hFD, 8'd5,  1'b1, 16'hFFF1, "s_m3x5");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
    op8(8'h00, 8'hFF, 1'b1, 16'h0000, "s_0xm1");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
    op8(8'd0,  8'd0,  1'b0, 16'h0000, "u_0x0");

    // Busy behaviour: start pulses at k+3 (RUN) and k+9 (DONE) are ignored
    @(negedge clk); a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);                                   // edge k
    @(negedge clk); start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b1;
    repeat (2) @(posedge clk);                        // edges k+1, k+2
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);                                   // edge k+3
    @(negedge clk); start8 = 1'b0;
    repeat (5) @(posedge clk);                        // edge k+8
    #1;
    chk(32'(done8), 32'd1, "busy_done");
    chk(32'(ab8), 32'd63, "busy_ab");
    @(negedge clk); start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(posedge clk); #1;                               // edge k+9
    chk(32'({busy8, done8}), 32'd0, "busy_done_pulse_ignored");
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(32'(busy8), 32'd0, "busy_still_idle");
    chk(32'(ab8), 32'd63, "busy_ab_hold");

    // Reset mid-RUN at edge k+4
    @(negedge clk); a8 = 8'd26; b8 = 8'd80; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);                                   // edge k
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;                               // edge k+4
    chk(32'(ab8), 32'd0, "midrst_ab");
    chk(32'({busy8, done8}), 32'd0, "midrst_bd");
    @(negedge clk); rst = 1'b0;
    op8(8'd26, 8'd80, 1'b0, 16'd2080, "after_rst");

    // Reset together with start stays in IDLE
    @(negedge clk); rst = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    chk(32'(busy8), 32'd0, "rst_start_busy");
    @(negedge clk); rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk(32'({busy8, done8}), 32'd0, "rst_start_idle");
    chk(32'(ab8), 32'd0, "rst_start_ab");

    // WIDTH = 16 directed: -1234 x 5678 = -7006652
    op16(16'hFB2E, 16'd5678, 1'b1, 32'hFF95_1644, "w16_signed");
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "w16_umax");
    op16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_minmin");

    // WIDTH = 16 random, 1000 pairs per mode
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        op16(ra, rb, m[0], ref16(ra, rb, m[0]), m[0] ? "rand_s" : "rand_u");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_add_mult
`default_nettype wire
